// File: rtl/pc_pkg.sv
// pc_pkg: state encoding and constants shared by the PC sequencer and its testbench.
package pc_pkg;
    localparam int STATE_W = 2;
    localparam int PC_INC = 4;
    typedef enum logic [STATE_W-1:0] {
        RUN     = 2'd0,
        HANDLER = 2'd1,
        HALT    = 2'd2
    } pc_state_e;
endpackage

// File: rtl/pc_ras.sv
// pc_ras: circular return-address stack; a full push overwrites the oldest entry, and the count saturates.
module pc_ras #(
    parameter int XLEN      = 64,
    parameter int RAS_DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            push,
    input  logic            pop,
    input  logic [XLEN-1:0] data,
    output logic [XLEN-1:0] top,
    output logic            valid
);
    localparam int PW = $clog2(RAS_DEPTH);
    localparam logic [PW:0] FULL = RAS_DEPTH[PW:0];
    logic [XLEN-1:0] mem [RAS_DEPTH];
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   top_idx;
    logic [PW:0]     count;
    assign top_idx = ptr - 1'b1;
    assign top     = mem[top_idx];
    assign valid   = count != '0;
    // push+pop rewrites the top slot in place, so pointer and count stay put
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr   <= '0;
            count <= '0;
        end else if (push && !pop) begin
            ptr   <= ptr + 1'b1;
            count <= (count == FULL) ? count : count + 1'b1;
        end else if (pop && !push && valid) begin
            ptr   <= ptr - 1'b1;
            count <= count - 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        if (push) mem[pop ? top_idx : ptr] <= data;
    end
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: next-PC selection with traps, mret, and misalignment faults.
// The optional return-address stack is built only when PC_SEQUENCER_RAS_EN is defined.
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int              XLEN      = 64,
    parameter logic [XLEN-1:0] RESET_VEC = '0,
    parameter int              RAS_DEPTH = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic               branch,
    input  logic               cond_met,
    input  logic               jal,
    input  logic               jalr,
    input  logic [XLEN-1:0]    imm,
    input  logic [XLEN-1:0]    rs1_val,
    input  logic               link,
    input  logic               is_ret,
    input  logic               trap,
    input  logic               mret,
    input  logic [XLEN-1:0]    trap_vec,
    output logic [XLEN-1:0]    pc,
    output logic [XLEN-1:0]    pc_plus4,
    output logic [XLEN-1:0]    epc,
    output logic [STATE_W-1:0] state,
    output logic               misalign,
    output logic [XLEN-1:0]    ras_top,
    output logic               ras_valid
);
    localparam logic [STATE_W-1:0] S_RUN     = RUN;
    localparam logic [STATE_W-1:0] S_HANDLER = HANDLER;
    localparam logic [STATE_W-1:0] S_HALT    = HALT;
    logic [XLEN-1:0] br_tgt, jr_sum, jr_tgt, tgt;
    logic            taken, mis, halted, fault, ret_ok, upd;
    assign pc_plus4 = pc + XLEN'(PC_INC);
    assign br_tgt   = pc + imm;
    assign jr_sum   = rs1_val + imm;
    assign jr_tgt   = {jr_sum[XLEN-1:1], 1'b0};
    assign taken    = jalr | jal | (branch & cond_met);
    assign tgt      = jalr ? jr_tgt : br_tgt;
    assign mis      = taken & tgt[1];
    assign halted   = state == S_HALT;
    assign fault    = trap | mis;
    assign ret_ok   = mret & (state == S_HANDLER);
    assign upd      = !halted && !fault && !stall;
    // a fault while already in the handler is a double fault and freezes the core
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc       <= RESET_VEC;
            epc      <= '0;
            state    <= S_RUN;
            misalign <= 1'b0;
        end else if (!halted) begin
            misalign <= mis & !trap;
            if (fault) begin
                if (state == S_RUN) begin
                    epc   <= pc;
                    pc    <= trap_vec;
                    state <= S_HANDLER;
                end else begin
                    state <= S_HALT;
                end
            end else if (!stall) begin
                pc <= ret_ok ? epc : taken ? tgt : pc_plus4;
                if (ret_ok) state <= S_RUN;
            end
        end else begin
            misalign <= 1'b0;
        end
    end
`ifdef PC_SEQUENCER_RAS_EN
    logic jump_upd;
    assign jump_upd = upd & !ret_ok;
    pc_ras #(.XLEN(XLEN), .RAS_DEPTH(RAS_DEPTH)) u_ras (
        .clk   (clk),
        .reset (reset),
        .push  (jump_upd & (jal | jalr) & link),
        .pop   (jump_upd & jalr & is_ret),
        .data  (pc_plus4),
        .top   (ras_top),
        .valid (ras_valid)
    );
`else
    logic unused_ras;
    assign unused_ras = ^{link, is_ret, upd, RAS_DEPTH[0]};
    assign ras_top    = '0;
    assign ras_valid  = 1'b0;
`endif
endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter XLEN, default 64: PC and operand width.
REQ-002 SHALL have parameter RESET_VEC, default 0: PC value loaded on reset.
REQ-003 SHALL have parameter RAS_DEPTH, default 4: return-address-stack entries, power of two, at least 2.
REQ-004 SHALL have port clk, input, 1: rising-edge clock.
REQ-005 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port stall, input, 1: hold the PC this cycle.
REQ-007 SHALL have port branch, input, 1: conditional branch in flight.
REQ-008 SHALL have port cond_met, input, 1: comparator result for branch.
REQ-009 SHALL have ports jal and jalr, each input, 1: unconditional jumps.
REQ-010 SHALL have ports imm and rs1_val, each input, XLEN: offset and register base.
REQ-011 SHALL have ports link and is_ret, each input, 1: the jump writes the return register, and the jump is a return.
REQ-012 SHALL have ports trap and mret, each input, 1: take an exception, and return from it.
REQ-013 SHALL have port trap_vec, input, XLEN: handler address.
REQ-014 SHALL have ports pc, pc_plus4 and epc, each output, XLEN: current PC, PC+4, saved exception PC.
REQ-015 SHALL have port state, output, 2: RUN=0, HANDLER=1, HALT=2.
REQ-016 SHALL have port misalign, output, 1: the last update attempted a misaligned target.
REQ-017 SHALL have ports ras_top, output, XLEN, and ras_valid, output, 1: return-address prediction.

Function
REQ-018 pc_plus4 SHALL be pc+4, combinational, modulo 2^XLEN.
REQ-019 Targets SHALL be computed as follows: branch/jal = pc+imm; jalr = (rs1_val+imm) with bit0 cleared; all modulo 2^XLEN.
REQ-020 Next-PC priority SHALL be: HALT hold > trap > misaligned target > stall > mret > jalr > jal > (branch & cond_met) > pc+4.
REQ-021 A selected jump/branch target with bit1=1 SHALL not be loaded; it SHALL be handled as a trap to trap_vec and set misalign=1 for one cycle.
REQ-022 RUN + trap SHALL load epc<=pc and pc<=trap_vec, and move to HANDLER; trap overrides stall.
REQ-023 HANDLER + trap, or a misaligned target in HANDLER, SHALL move to HALT (double fault) with pc and epc unchanged.
REQ-024 HANDLER + mret SHALL load pc<=epc and move to RUN; mret in RUN SHALL be ignored and the PC advances normally.
REQ-025 HALT SHALL hold all state; HALT SHALL be exited only by reset.
REQ-026 The PC SHALL update one cycle after the inputs are sampled; there SHALL be no additional latency.

Reset
REQ-027 On reset, the block SHALL set pc=RESET_VEC, epc=0, state=RUN, misalign=0, RAS count=0 and ras_valid=0, immediately and asynchronously.
REQ-028 Reset asserted mid-trap or mid-stall SHALL discard the pending update.

Configuration
REQ-029 With macro PC_SEQUENCER_RAS_EN defined, the RAS SHALL push pc_plus4 on (jal|jalr) & link, and pop on jalr & is_ret, only when the PC actually updates (not stalled, not trapped, not HALT).
REQ-030 A simultaneous push and pop SHALL replace the top entry with the count unchanged.
REQ-031 A push when full SHALL overwrite the oldest entry with count saturated at RAS_DEPTH; a pop when empty SHALL leave count=0.
REQ-032 ras_valid SHALL equal (count!=0), and ras_top SHALL be the top entry.
REQ-033 Without PC_SEQUENCER_RAS_EN, no RAS storage SHALL exist; ras_valid and ras_top SHALL be tied to 0.

Structure
REQ-034 Package pc_pkg SHALL hold the state enum (RUN/HANDLER/HALT), the 2-bit state width and the PC increment constant 4.
REQ-035 The RAS SHALL be a sub-module, pc_ras, parameterised by XLEN and RAS_DEPTH, with a circular pointer and a saturating count.

Verification
REQ-036 Reset with RESET_VEC=0x1000, then 3 idle cycles -> pc=0x1000, 0x1004, 0x1008, 0x100C.
REQ-037 pc=0x2000, branch=1, cond_met=1, imm=0x40 -> pc=0x2040; same with cond_met=0 -> pc=0x2004.
REQ-038 pc=0x3000, jalr, rs1_val=0x5001, imm=0 -> pc=0x5000; imm=2 -> pc=trap_vec, misalign=1, epc=0x3000, state=HANDLER.
REQ-039 In HANDLER: trap -> state=HALT with pc frozen for 10 cycles; a subsequent reset -> pc=RESET_VEC, state=RUN.
REQ-040 From RUN at pc=0x100 with stall=1: trap (trap_vec=0x800) -> pc=0x800, epc=0x100; then mret -> pc=0x100, state=RUN.
REQ-041 With RAS_EN and RAS_DEPTH=4: 5 linked jal pushes, then 5 returns -> ras_top follows the last four return addresses in reverse order, then ras_valid=0; a simultaneous push+pop leaves count unchanged.
